// File: rtl/dram_traffic_gen.sv
// Write/read-back traffic generator and checker for the MIG 7-series app port.
// Fills NUM_WORDS UI words with a pattern, reads them back and counts mismatches.
module dram_traffic_gen #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 128,
  parameter int NUM_WORDS   = 3840,
  parameter int ADDR_STRIDE = 8,
  parameter int BASE_ADDR   = 0,
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                loop_en,
  input  logic [1:0]          pattern_sel,
  input  logic                init_calib_complete,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic                app_rd_data_valid,
  input  logic                app_rd_data_end,
  input  logic [DATA_W-1:0]   app_rd_data,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         error_count,
  output logic [IDX_W-1:0]    first_err_index,
  output logic [15:0]         pass_count
);

  localparam int LANES = DATA_W / 32;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CAL,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  function automatic logic [DATA_W-1:0] pat_f(
    input logic [1:0]       sel,
    input logic [CNT_W-1:0] idx
  );
    logic [DATA_W-1:0] w;
    logic [31:0]       v;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      v = 32'(idx) * 32'(LANES) + 32'(k);
      case (sel)
        2'd1:    w[k*32 +: 32] = v;
        2'd2:    w[k*32 +: 32] = ~v;
        default: w[k*32 +: 32] = 32'h00AAAA00;
      endcase
    end
    return w;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_f(
    input logic [CNT_W-1:0] idx
  );
    return ADDR_W'(64'(BASE_ADDR) + 64'(idx) * 64'(ADDR_STRIDE));
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic              cmp_err_q, cmp_err_d;
  logic [IDX_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cmdo_q, cmdo_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       err_q, err_d;
  logic [IDX_W-1:0]  first_q, first_d;
  logic [15:0]       pcnt_q, pcnt_d;

  logic [CNT_W-1:0]  cmd_nx, wd_nx, rd_nx;
  logic              go_start, go_write;
  logic              unused_rd_end;

  assign cmd_nx = cmd_cnt_q + CNT_W'(1);
  assign wd_nx  = wd_cnt_q + CNT_W'(1);
  assign rd_nx  = rd_cnt_q + CNT_W'(1);
  assign unused_rd_end = app_rd_data_end;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cmd_cnt_d = cmd_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    cmp_vld_d = 1'b0;
    cmp_err_d = 1'b0;
    cmp_idx_d = cmp_idx_q;
    addr_d    = addr_q;
    cmdo_d    = cmdo_q;
    en_d      = en_q;
    wdata_d   = wdata_q;
    wren_d    = wren_q;
    err_d     = err_q;
    first_d   = first_q;
    pcnt_d    = pcnt_q;
    go_start  = 1'b0;
    go_write  = 1'b0;

    // Second comparator stage: fold the registered compare into the counters.
    if (cmp_vld_q && cmp_err_q) begin
      if (err_q == 16'd0) first_d = cmp_idx_q;
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: go_start = start;
      S_WAIT_CAL: go_write = init_calib_complete;
      S_WRITE: begin
        if (en_q && app_rdy) begin
          cmd_cnt_d = cmd_nx;
          en_d      = cmd_nx < LAST;
          addr_d    = addr_f(cmd_nx);
        end
        if (wren_q && app_wdf_rdy) begin
          wd_cnt_d = wd_nx;
          wren_d   = wd_nx < LAST;
          wdata_d  = (wd_nx < LAST) ? pat_f(sel_q, wd_nx) : '0;
        end
        if (cmd_cnt_q == LAST && wd_cnt_q == LAST) begin
          state_d   = S_READ;
          cmd_cnt_d = '0;
          en_d      = 1'b1;
          addr_d    = addr_f(CNT_W'(0));
          cmdo_d    = 3'b001;
          wren_d    = 1'b0;
          wdata_d   = '0;
        end
      end
      S_READ: begin
        if (en_q && app_rdy) begin
          cmd_cnt_d = cmd_nx;
          en_d      = cmd_nx < LAST;
          addr_d    = addr_f(cmd_nx);
        end
        if (app_rd_data_valid && rd_cnt_q < LAST) begin
          rd_cnt_d  = rd_nx;
          cmp_vld_d = 1'b1;
          cmp_err_d = app_rd_data != pat_f(sel_q, rd_cnt_q);
          cmp_idx_d = IDX_W'(rd_cnt_q);
        end
        if (rd_cnt_q == LAST) begin
          state_d = S_DONE;
          en_d    = 1'b0;
          pcnt_d  = pcnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (loop_en) go_write = 1'b1;
        else go_start = start;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_start) begin
      state_d = S_WAIT_CAL;
      sel_d   = pattern_sel;
      err_d   = '0;
      first_d = '0;
      pcnt_d  = '0;
    end

    if (go_write) begin
      state_d   = S_WRITE;
      cmd_cnt_d = '0;
      wd_cnt_d  = '0;
      rd_cnt_d  = '0;
      en_d      = 1'b1;
      addr_d    = addr_f(CNT_W'(0));
      cmdo_d    = 3'b000;
      wren_d    = 1'b1;
      wdata_d   = pat_f(sel_q, CNT_W'(0));
    end
  end

  assign busy_d = (state_d == S_WAIT_CAL) ||
                  (state_d == S_WRITE) ||
                  (state_d == S_READ);
  assign done_d = state_d == S_DONE;
  assign pass_d = done_d && (err_d == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cmd_cnt_q <= '0;
      wd_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      cmp_vld_q <= 1'b0;
      cmp_err_q <= 1'b0;
      cmp_idx_q <= '0;
      addr_q    <= '0;
      cmdo_q    <= '0;
      en_q      <= 1'b0;
      wdata_q   <= '0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cmd_cnt_q <= cmd_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_err_q <= cmp_err_d;
      cmp_idx_q <= cmp_idx_d;
      addr_q    <= addr_d;
      cmdo_q    <= cmdo_d;
      en_q      <= en_d;
      wdata_q   <= wdata_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      first_q   <= first_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign app_addr        = addr_q;
  assign app_cmd         = cmdo_q;
  assign app_en          = en_q;
  assign app_wdf_data    = wdata_q;
  assign app_wdf_wren    = wren_q;
  assign app_wdf_end     = wren_q;
  assign app_wdf_mask    = '0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_err_index = first_q;
  assign pass_count      = pcnt_q;

endmodule

// File: tb/tb_dram_traffic_gen.sv
// Bench for dram_traffic_gen: a small MIG memory model plus
// per-scenario tasks checking against spec-level expectations.
module tb_dram_traffic_gen;

  localparam int NW = 16;
  localparam int DW = 128;
  localparam int AW = 27;
  localparam int ST = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          loop_en = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          init_calib_complete = 1'b1;
  logic          app_rdy = 1'b1;
  logic          app_wdf_rdy = 1'b1;
  logic          app_rd_data_valid = 1'b0;
  logic          app_rd_data_end = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   error_count;
  logic [3:0]    first_err_index;
  logic [15:0]   pass_count;

  dram_traffic_gen #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW),
    .ADDR_STRIDE(ST), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .loop_en(loop_en),
    .pattern_sel(pattern_sel),
    .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .app_rd_data(app_rd_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count),
    .first_err_index(first_err_index),
    .pass_count(pass_count)
  );

  int n_checks = 0;
  int n_fail = 0;

  // MIG model knobs and logs
  int rdy_mode = 0;
  int hold_cnt = 0;
  bit rd_rand = 0;
  logic [15:0] corrupt = '0;
  int cyc = 0;
  int rd_beats = 0;
  int hold_viol = 0;
  int cl_cmd[$];
  int cl_addr[$];
  int cl_cyc[$];
  logic [DW-1:0] dlog[$];
  int wq[$];
  logic [DW-1:0] wdq[$];
  int rq_a[$];
  int rq_t[$];
  logic [DW-1:0] mem[int];

  logic          p_en = 0, p_rdy = 0, p_wr = 0, p_wrdy = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;
  int            m_a;
  logic [DW-1:0] m_d;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rdy_mode == 0) begin
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
      end else if (rdy_mode == 2 && hold_cnt > 0) begin
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b1;
        hold_cnt--;
      end else begin
        app_rdy = 1'($urandom_range(0, 1));
        app_wdf_rdy = 1'($urandom_range(0, 1));
      end
      if (p_en && !p_rdy && (!app_en || app_addr !== p_addr))
        hold_viol++;
      if (p_wr && !p_wrdy &&
          (!app_wdf_wren || app_wdf_data !== p_data))
        hold_viol++;
      p_en = app_en;
      p_rdy = app_rdy;
      p_addr = app_addr;
      p_wr = app_wdf_wren;
      p_wrdy = app_wdf_rdy;
      p_data = app_wdf_data;
      if (!reset && app_en && app_rdy) begin
        cl_cmd.push_back(int'(app_cmd));
        cl_addr.push_back(int'(app_addr));
        cl_cyc.push_back(cyc);
        if (app_cmd == 3'b000) wq.push_back(int'(app_addr));
        if (app_cmd == 3'b001) begin
          rq_a.push_back(int'(app_addr));
          rq_t.push_back(cyc + 3);
        end
      end
      if (!reset && app_wdf_wren && app_wdf_rdy) begin
        dlog.push_back(app_wdf_data);
        wdq.push_back(app_wdf_data);
      end
      while (wq.size() > 0 && wdq.size() > 0)
        mem[wq.pop_front()] = wdq.pop_front();
      if (rq_a.size() > 0 && rq_t[0] <= cyc &&
          (!rd_rand || $urandom_range(0, 1) == 1)) begin
        m_a = rq_a.pop_front();
        void'(rq_t.pop_front());
        m_d = mem.exists(m_a) ? mem[m_a] : '0;
        if (m_a / ST < 16 && corrupt[m_a / ST]) m_d[0] = ~m_d[0];
        app_rd_data_valid = 1'b1;
        app_rd_data_end = 1'b1;
        app_rd_data = m_d;
        rd_beats++;
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data_end = 1'b0;
        app_rd_data = {4{$urandom}};
      end
    end
  end

  function automatic logic [DW-1:0] ref_word(input int sel, input int i);
    logic [DW-1:0] w;
    logic [31:0] v;
    for (int k = 0; k < DW / 32; k++) begin
      v = 32'(i * (DW / 32) + k);
      if (sel == 1) w[k*32 +: 32] = v;
      else if (sel == 2) w[k*32 +: 32] = ~v;
      else w[k*32 +: 32] = 32'h00AAAA00;
    end
    return w;
  endfunction

  function automatic int n_cmds(input int c);
    int n = 0;
    foreach (cl_cmd[i]) if (cl_cmd[i] == c) n++;
    return n;
  endfunction

  function automatic int bad_addrs(input int c);
    int n = 0, bad = 0;
    foreach (cl_cmd[i]) begin
      if (cl_cmd[i] == c) begin
        if (cl_addr[i] != n * ST) bad++;
        n++;
      end
    end
    return bad;
  endfunction

  function automatic int bad_data(input int sel);
    int bad = 0;
    foreach (dlog[i]) if (dlog[i] !== ref_word(sel, i)) bad++;
    return bad;
  endfunction

  task automatic clear_logs();
    cl_cmd.delete();
    cl_addr.delete();
    cl_cyc.delete();
    dlog.delete();
    rd_beats = 0;
    hold_viol = 0;
  endtask

  task automatic run_pass(input int sel, input int mid, output bit ok);
    @(negedge clk);
    clear_logs();
    pattern_sel = 2'(sel);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      if (i == mid) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({app_en, app_addr, app_cmd, app_wdf_wren, app_wdf_end,
         app_wdf_data, app_wdf_mask, busy, done, pass,
         error_count, first_err_index, pass_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%0b addr=%0d busy=%0b, required all 0",
               app_en, app_addr, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_clean();
    bit ok;
    int gaps;
    rdy_mode = 0;
    rd_rand = 0;
    corrupt = '0;
    @(negedge clk);
    clear_logs();
    pattern_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || app_en !== 1'b0) begin
      n_fail++;
      $display("FAIL start_lat1: busy=%0b en=%0b, required 1 0", busy, app_en);
    end
    @(negedge clk);
    n_checks++;
    if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_addr !== '0) begin
      n_fail++;
      $display("FAIL start_lat2: en=%0b wren=%0b addr=%0d, required 1 1 0",
               app_en, app_wdf_wren, app_addr);
    end
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL clean_timeout: done=0, required 1");
    end
    n_checks++;
    if (n_cmds(0) != NW || n_cmds(1) != NW) begin
      n_fail++;
      $display("FAIL clean_cmd_count: wr=%0d rd=%0d, required %0d",
               n_cmds(0), n_cmds(1), NW);
    end
    n_checks++;
    if (bad_addrs(0) != 0 || bad_addrs(1) != 0) begin
      n_fail++;
      $display("FAIL clean_addrs: bad wr=%0d rd=%0d, required 0",
               bad_addrs(0), bad_addrs(1));
    end
    n_checks++;
    if (dlog.size() != NW || bad_data(0) != 0) begin
      n_fail++;
      $display("FAIL clean_data: beats=%0d bad=%0d, required %0d 0",
               dlog.size(), bad_data(0), NW);
    end
    gaps = 0;
    for (int i = 1; i < NW && i < cl_cyc.size(); i++)
      if (cl_cyc[i] != cl_cyc[i-1] + 1) gaps++;
    n_checks++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL back_to_back: gaps=%0d, required 0", gaps);
    end
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1 || error_count !== 16'd0 ||
        pass_count !== 16'd1) begin
      n_fail++;
      $display("FAIL clean_status: done=%0b pass=%0b err=%0d pc=%0d, required 1 1 0 1",
               done, pass, error_count, pass_count);
    end
  endtask

  task automatic test_mismatch();
    bit ok;
    int exp_err, exp_first;
    rdy_mode = 0;
    rd_rand = 1;
    corrupt = '0;
    corrupt[5] = 1'b1;
    corrupt[9] = 1'b1;
    exp_err = $countones(corrupt);
    exp_first = -1;
    for (int i = 15; i >= 0; i--) if (corrupt[i]) exp_first = i;
    run_pass(1, -1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mismatch_timeout: done=0, required 1");
    end
    n_checks++;
    if (bad_data(1) != 0 || dlog.size() != NW) begin
      n_fail++;
      $display("FAIL mismatch_wdata: bad=%0d, required 0", bad_data(1));
    end
    n_checks++;
    if (error_count !== 16'(exp_err) || first_err_index !== 4'(exp_first) ||
        pass !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_status: err=%0d first=%0d pass=%0b, required %0d %0d 0",
               error_count, first_err_index, pass, exp_err, exp_first);
    end
    corrupt = '0;
  endtask

  task automatic test_backpressure();
    bit ok;
    rd_rand = 1;
    rdy_mode = 2;
    hold_cnt = 12;
    run_pass(2, 20, ok);
    rdy_mode = 0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: done=0, required 1");
    end
    n_checks++;
    if (n_cmds(0) != NW || dlog.size() != NW) begin
      n_fail++;
      $display("FAIL bp_counts: cmds=%0d beats=%0d, required %0d",
               n_cmds(0), dlog.size(), NW);
    end
    n_checks++;
    if (hold_viol != 0) begin
      n_fail++;
      $display("FAIL bp_hold: violations=%0d, required 0", hold_viol);
    end
    n_checks++;
    if (bad_data(2) != 0 || bad_addrs(0) != 0 || bad_addrs(1) != 0) begin
      n_fail++;
      $display("FAIL bp_content: bad data=%0d, required 0", bad_data(2));
    end
    n_checks++;
    if (pass !== 1'b1 || pass_count !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_status: pass=%0b pc=%0d, required 1 1", pass, pass_count);
    end
  endtask

  task automatic test_calib();
    bit ok;
    int bad;
    rd_rand = 0;
    init_calib_complete = 1'b0;
    @(negedge clk);
    clear_logs();
    pattern_sel = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy !== 1'b1 || app_en !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL calib_wait: bad cycles=%0d, required 0", bad);
    end
    init_calib_complete = 1'b1;
    @(negedge clk);
    n_checks++;
    if (app_en !== 1'b1 || app_addr !== '0 || app_cmd !== 3'b000) begin
      n_fail++;
      $display("FAIL calib_first_cmd: en=%0b addr=%0d, required 1 0",
               app_en, app_addr);
    end
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok || pass !== 1'b1 || bad_data(0) != 0) begin
      n_fail++;
      $display("FAIL calib_run: done=%0b pass=%0b, required 1 1", done, pass);
    end
  endtask

  task automatic test_loop();
    bit ok;
    int idx, sel;
    idx = $urandom_range(0, 15);
    sel = $urandom_range(1, 2);
    rd_rand = 1;
    corrupt = '0;
    loop_en = 1'b1;
    @(negedge clk);
    clear_logs();
    pattern_sel = 2'(sel);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 8000; i++) begin
      if (pass_count == 16'd1) corrupt[idx] = 1'b1;
      if (pass_count == 16'd2) corrupt = '0;
      if (pass_count == 16'd3 && done) begin
        loop_en = 1'b0;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    loop_en = 1'b0;
    corrupt = '0;
    @(negedge clk);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL loop_timeout: pc=%0d, required 3", pass_count);
    end
    n_checks++;
    if (done !== 1'b1 || pass_count !== 16'd3 || error_count !== 16'd1) begin
      n_fail++;
      $display("FAIL loop_status: done=%0b pc=%0d err=%0d, required 1 3 1",
               done, pass_count, error_count);
    end
    n_checks++;
    if (first_err_index !== 4'(idx) || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_first: first=%0d pass=%0b, required %0d 0",
               first_err_index, pass, idx);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    rd_rand = 1;
    corrupt = '0;
    @(negedge clk);
    clear_logs();
    pattern_sel = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rd_beats >= 7) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    corrupt = 16'hFFFF;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_wait: beats=%0d, required 7", rd_beats);
    end
    n_checks++;
    if ({app_en, app_addr, app_cmd, app_wdf_wren, app_wdf_end,
         app_wdf_data, app_wdf_mask, busy, done, pass,
         error_count, first_err_index, pass_count} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs: en=%0b busy=%0b err=%0d, required 0",
               app_en, busy, error_count);
    end
    for (int i = 0; i < 300; i++) begin
      if (rq_a.size() == 0 && !app_rd_data_valid) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (error_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_late_beats: err=%0d busy=%0b done=%0b, required 0 0 0",
               error_count, busy, done);
    end
    corrupt = '0;
    rd_rand = 0;
    run_pass(2, -1, ok);
    n_checks++;
    if (!ok || pass !== 1'b1 || error_count !== 16'd0 ||
        pass_count !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_rerun: pass=%0b err=%0d pc=%0d, required 1 0 1",
               pass, error_count, pass_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_mismatch();
    test_backpressure();
    test_calib();
    test_loop();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
